pp_column_streamer: RTL and testbench
=====================================

Name: pp_column_streamer

Overview:
Producer end of the counter-tree interface: accepts two unsigned WIDTH-bit operands and streams the partial-product AND-array out one weight column per cycle. Column k carries every bit a[i]&b[k-i], LSB-aligned by row index. Downstream 3:2 / 7:3 counter stages consume one column per beat for sequential column-serial multiplication. Valid/ready on both sides; one multiplication in flight at a time.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16; also the maximum column height.
CW, $clog2(2*WIDTH-1), column index width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands
in_a  input  WIDTH  multiplicand, unsigned
in_b  input  WIDTH  multiplier, unsigned
out_valid  output  1  column beat valid
out_ready  input  1  consumer accepts beat
col_bits  output  WIDTH  bit i = a[i]&b[k-i] if 0<=k-i<WIDTH, else 0
col_idx  output  CW  column weight k, 0..2*WIDTH-2
col_last  output  1  high when col_idx == 2*WIDTH-2

Behaviour:
- Reset (async assert, sync-clean deassert): state IDLE, in_ready=1, out_valid=0, col_idx=0, col_bits=0, col_last=0, operand regs cleared.
- States: IDLE, STREAM.
- IDLE: in_ready=1, out_valid=0. On in_valid&in_ready at edge t: latch in_a/in_b, col_idx<=0, go STREAM. Column 0 presented with out_valid=1 in the cycle after edge t.
- STREAM: in_ready=0; in_valid is ignored and no operands are latched. out_valid=1 throughout.
- On out_valid&out_ready at an edge with col_idx<2*WIDTH-2: col_idx<=col_idx+1.
- On the handshake of the last column (col_last=1): go IDLE. out_valid=0 and in_ready=1 in the next cycle.
- out_ready low: col_idx, col_bits and col_last hold stable; no beat is dropped or duplicated.
- col_bits and col_last are derived from the latched operands and col_idx, either combinationally or registered. They must be valid and stable whenever out_valid=1.
- Throughput: 2*WIDTH cycles per operation with out_ready held high (1 accept cycle + 2*WIDTH-1 beats). Back-to-back requests therefore have exactly one idle cycle between col_last and the next column 0.
- Row i of a column never exceeds WIDTH-1. Column height is min(k+1, 2*WIDTH-1-k).
- Invariant: sum over k of popcount(col_bits_k)*2^k == in_a*in_b.
- Reset asserted mid-STREAM: immediate return to reset values. The partial stream is abandoned and the transaction is not resumed.
- in_a/in_b changing after acceptance has no effect on the current stream.

Optional Feature:
Macro PP_COL_COUNT_EN.
- Defined: adds output col_count (width $clog2(WIDTH+1)) = popcount(col_bits), valid with out_valid. It is the expected 3:2 / 7:3 counter result for that column, for in-line checking. Reset value 0; it holds under stall like col_bits.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, reset then in_a=4'b1011, in_b=4'b0110, out_ready=1 -> col_bits for k=0..6 = 0000, 0001, 0011, 0010, 1000, 1000, 0000; col_last only at k=6; weighted popcount sum = 66.
- in_a=in_b=4'hF -> columns 0001, 0011, 0111, 1111, 1110, 1100, 1000. With PP_COL_COUNT_EN, col_count = 1, 2, 3, 4, 3, 2, 1.
- Stall: out_ready=0 for 3 cycles while col_idx=2 (first vector) -> col_bits=0011 and col_idx=2 held for all 3 cycles; stream resumes at k=3 with no duplicate beat.
- in_valid held high with two vectors queued (1011x0110 then 4'hFx4'hF) -> in_ready=0 during STREAM; exactly one idle cycle after first col_last; second stream correct.
- rst pulsed while col_idx=4 -> out_valid=0 and in_ready=1 immediately; a new request 0001x0001 then yields 0001 at k=0 and 0000 for k=1..6.
- in_a/in_b toggled randomly during STREAM -> output columns match the operands latched at accept.

Source files
------------

// File: rtl/pp_column_streamer.sv
// ---------------------------------------------------------------------------
// pp_column_streamer
//
// Producer end of the counter-tree interface. Accepts one pair of unsigned
// WIDTH-bit operands and streams the partial-product AND-array out one
// weight column per beat, column 0 first, for column-serial multiplication
// in downstream 3:2 / 7:3 counter stages. One multiplication in flight.
//
// Optional feature: define PP_COL_COUNT_EN to add the col_count output
// (popcount of the current column, the expected counter result).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair offered
//   in_ready   block can accept operands (high only in IDLE)
//   in_a       multiplicand, unsigned
//   in_b       multiplier, unsigned
//   out_valid  column beat valid (high only in STREAM)
//   out_ready  consumer accepts beat
//   col_bits   bit i = a[i] & b[k-i] when 0 <= k-i < WIDTH, else 0
//   col_idx    column weight k, 0 .. 2*WIDTH-2
//   col_last   high when col_idx == 2*WIDTH-2
//   col_count  (PP_COL_COUNT_EN only) popcount(col_bits)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once out_valid is raised it stays high, and col_bits/col_idx/
// col_last stay stable, until the beat is taken; in_valid is ignored while
// in_ready is low.
// ---------------------------------------------------------------------------
module pp_column_streamer #(
   parameter  int WIDTH = 4,
   localparam int CW    = $clog2(2*WIDTH-1),
   localparam int CNTW  = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] col_bits,
   output logic [CW-1:0]    col_idx,
   output logic             col_last
`ifdef PP_COL_COUNT_EN
   ,
   output logic [CNTW-1:0]  col_count
`endif
);

   localparam logic [CW-1:0] LAST_IDX = CW'(2*WIDTH-2);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    idx_q;
   logic             accept;
   logic             beat;

   assign accept = in_valid & in_ready;
   assign beat   = out_valid & out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)            state_nxt = STREAM;
         STREAM:  if (beat && col_last)  state_nxt = IDLE;
         default:                        state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         STREAM:  out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Operand and column-index registers. Operands are captured only on
   // accept, so input changes during a stream cannot reach the columns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         idx_q <= '0;
      end else begin
         if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            idx_q <= '0;
         end else if (beat && (idx_q < LAST_IDX)) begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign col_idx  = idx_q;
   assign col_last = (idx_q == LAST_IDX);

   // Column k gathers every product bit a[i]&b[j] with i+j == k, placed at
   // row i. Derived purely from registered state, so it is stable under stall.
   always_comb begin
      col_bits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if ((i + j) == int'(idx_q)) begin
               col_bits[i] = col_bits[i] | (a_q[i] & b_q[j]);
            end
         end
      end
   end

`ifdef PP_COL_COUNT_EN
   always_comb begin
      col_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         col_count = col_count + {{(CNTW-1){1'b0}}, col_bits[i]};
      end
   end
`endif

endmodule

// File: tb/tb_pp_column_streamer.sv
module tb_pp_column_streamer;

   localparam int WIDTH = 4;
   localparam int CW    = $clog2(2*WIDTH-1);
   localparam int NCOL  = 2*WIDTH-1;
   localparam int EW    = 1 + CW + WIDTH;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] col_bits;
   logic [CW-1:0]    col_idx;
   logic             col_last;
`ifdef PP_COL_COUNT_EN
   logic [$clog2(WIDTH+1)-1:0] col_count;
`endif

   always #5 clk = ~clk;

   pp_column_streamer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .col_bits  (col_bits),
      .col_idx   (col_idx),
      .col_last  (col_last)
`ifdef PP_COL_COUNT_EN
      ,
      .col_count (col_count)
`endif
   );

   // ---------------- checking ----------------
   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Column k of a*b: row i holds a[i]&b[k-i] when that multiplier bit exists.
   function automatic logic [WIDTH-1:0] model_col(input int a, input int b, input int k);
      logic [WIDTH-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if ((k - i) >= 0 && (k - i) < WIDTH)
            c[i] = ((a >> i) & 1) & ((b >> (k - i)) & 1);
      end
      return c;
   endfunction

   // ---------------- scoreboard ----------------
   logic [EW-1:0]    exp_q[$];
   longint           prod_q[$];
   longint           wsum = 0;
   int               done_cnt = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_bits;
   logic [CW-1:0]    prev_idx;

   always @(negedge clk) begin
      if (!rst) begin
         // Busy exactly from accept until the last column has been taken.
         check_eq("in_ready", in_ready, exp_q.size() == 0);
         check_eq("out_valid", out_valid, exp_q.size() != 0);
         if (prev_stall) begin
            check_eq("stall_idx", col_idx, prev_idx);
            check_eq("stall_bits", col_bits, prev_bits);
         end
         prev_stall = out_valid && !out_ready;
         prev_bits  = col_bits;
         prev_idx   = col_idx;
         if (in_valid && in_ready) begin
            for (int k = 0; k < NCOL; k++)
               exp_q.push_back({(k == NCOL-1), CW'(k), model_col(int'(in_a), int'(in_b), k)});
            prod_q.push_back(longint'(in_a) * longint'(in_b));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_beat", 1, 0);
            end else begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check_eq("col_bits", col_bits, e[WIDTH-1:0]);
               check_eq("col_idx", col_idx, e[WIDTH+CW-1:WIDTH]);
               check_eq("col_last", col_last, e[EW-1]);
`ifdef PP_COL_COUNT_EN
               check_eq("col_count", col_count, $countones(e[WIDTH-1:0]));
`endif
               wsum += longint'($countones(col_bits)) << col_idx;
               if (col_last) begin
                  check_eq("weighted_sum", wsum, prod_q.size() != 0 ? prod_q.pop_front() : -1);
                  wsum = 0;
                  done_cnt++;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int budget;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 100) begin
         budget++;
         @(negedge clk);
      end
      if (!in_ready) check_eq("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Runs until the stream drains; optionally randomizes out_ready and
   // scrambles the operand inputs each cycle.
   task automatic drain(input bit scramble);
      int budget;
      budget = 0;
      while ((out_valid || exp_q.size() != 0) && budget < 400) begin
         @(posedge clk);
         #1;
         budget++;
         if (scramble) begin
            out_ready = 1'($urandom_range(0, 1));
            in_a = WIDTH'($urandom);
            in_b = WIDTH'($urandom);
         end
      end
      if (out_valid) check_eq("drain_timeout", 0, 1);
      out_ready = 1'b1;
   endtask

   task automatic wait_idx(input int k);
      int budget;
      budget = 0;
      while (!(out_valid && col_idx == CW'(k)) && budget < 100) begin
         @(posedge clk);
         #1;
         budget++;
      end
      if (!(out_valid && col_idx == CW'(k))) check_eq("wait_idx_timeout", 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int budget;
      int start_done;
      rst = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_col_idx", col_idx, 0);
      check_eq("rst_col_bits", col_bits, 0);
      check_eq("rst_col_last", col_last, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic vectors
      send(4'b1011, 4'b0110);
      drain(0);
      send(4'hF, 4'hF);
      drain(0);

      // Stall at column 2 for three cycles
      send(4'b1011, 4'b0110);
      wait_idx(2);
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check_eq("hold_idx", col_idx, 2);
         check_eq("hold_bits", col_bits, 4'b0011);
         check_eq("hold_valid", out_valid, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain(0);

      // Back-to-back with in_valid held high
      start_done = done_cnt;
      in_valid = 1'b1;
      in_a = 4'b1011;
      in_b = 4'b0110;
      @(negedge clk);
      @(posedge clk);
      #1;
      in_a = 4'hF;
      in_b = 4'hF;
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 100) begin
         check_eq("b2b_in_ready_low", in_ready, 0);
         budget++;
         @(negedge clk);
      end
      check_eq("b2b_gap_idle", out_valid, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain(0);
      check_eq("b2b_streams", done_cnt - start_done, 2);

      // Reset in the middle of a stream
      send(4'b1011, 4'b0110);
      wait_idx(4);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_in_ready", in_ready, 1);
      check_eq("mid_rst_col_idx", col_idx, 0);
      check_eq("mid_rst_col_bits", col_bits, 0);
      exp_q.delete();
      prod_q.delete();
      wsum = 0;
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(4'b0001, 4'b0001);
      drain(0);

      // Randomized operands, backpressure and scrambled inputs
      for (int n = 0; n < 25; n++) begin
         out_ready = 1'($urandom_range(0, 1));
         send(WIDTH'($urandom), WIDTH'($urandom));
         drain(1);
      end
      repeat (2) @(posedge clk);

      check_eq("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
